// File: rtl/mdr_div_sequencer_if.sv
// Operand/result bundle between the MDR operation decoder and the divide sequencer.
// Handshake: a request is accepted on the rising edge where i_start=1 and o_ready=1; results are valid while o_done=1.
interface mdr_div_sequencer_if #(
  parameter int DW = 16,
  parameter int CW = $clog2(DW) + 1
);
  logic          i_start;
  logic          i_signed;
  logic [DW-1:0] i_dividend;
  logic [DW-1:0] i_divisor;
  logic          o_ready;
  logic          o_shift_en;
  logic [CW-1:0] o_count;
  logic          o_done;
  logic          o_div_by_zero;
  logic [DW-1:0] o_quotient;
  logic [DW-1:0] o_remainder;
  logic [2:0]    o_dbg_state;

  modport master (
    output i_start, i_signed, i_dividend, i_divisor,
    input  o_ready, o_shift_en, o_count, o_done, o_div_by_zero,
    input  o_quotient, o_remainder, o_dbg_state
  );

  modport slave (
    input  i_start, i_signed, i_dividend, i_divisor,
    output o_ready, o_shift_en, o_count, o_done, o_div_by_zero,
    output o_quotient, o_remainder, o_dbg_state
  );
endinterface

// File: rtl/mdr_div_sequencer.sv
// Restoring radix-2 divide sequencer: magnitude divide over DW shift cycles,
// then sign correction so the remainder follows the dividend sign.
module mdr_div_sequencer #(
  parameter int DW = 16,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic clk,
  input  logic rst,
  mdr_div_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          signed_q, signed_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic [DW-1:0] mag_b_q, mag_b_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] res_q_q, res_q_d;
  logic [DW-1:0] res_r_q, res_r_d;
  logic          dz_q, dz_d;

  logic [DW:0]   shifted;
  logic [DW:0]   trial;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic [DW-1:0] fix_q;
  logic [DW-1:0] fix_r;

  always_comb begin
    mag_a   = (signed_q && dividend_q[DW-1]) ? -dividend_q : dividend_q;
    mag_b   = (signed_q && divisor_q[DW-1])  ? -divisor_q  : divisor_q;
    // Shifted remainder needs DW+1 bits: it can reach 2*(divisor-1)+1.
    shifted = {rem_q, quo_q[DW-1]};
    trial   = shifted - {1'b0, mag_b_q};
    fix_q   = negq_q ? -quo_q : quo_q;
    fix_r   = negr_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    signed_d   = signed_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    mag_b_d    = mag_b_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    count_d    = count_q;
    res_q_d    = res_q_q;
    res_r_d    = res_r_q;
    dz_d       = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          signed_d   = bus.i_signed;
          negq_d     = bus.i_signed & (bus.i_dividend[DW-1] ^ bus.i_divisor[DW-1]);
          negr_d     = bus.i_signed & bus.i_dividend[DW-1];
          dividend_d = bus.i_dividend;
          divisor_d  = bus.i_divisor;
          res_q_d    = '0;
          res_r_d    = '0;
          dz_d       = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        rem_d   = '0;
        quo_d   = mag_a;
        mag_b_d = mag_b;
        count_d = '0;
        if (divisor_q == '0) begin
          res_q_d = '1;
          res_r_d = dividend_q;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (!trial[DW]) begin
          rem_d = trial[DW-1:0];
          quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
          rem_d = shifted[DW-1:0];
          quo_d = {quo_q[DW-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(DW - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        quo_d   = fix_q;
        rem_d   = fix_r;
        res_q_d = fix_q;
        res_r_d = fix_r;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      signed_q   <= 1'b0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      mag_b_q    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      res_q_q    <= '0;
      res_r_q    <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      signed_q   <= signed_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      mag_b_q    <= mag_b_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      res_q_q    <= res_q_d;
      res_r_q    <= res_r_d;
      dz_q       <= dz_d;
    end
  end

  assign bus.o_ready       = (state_q == S_IDLE);
  assign bus.o_shift_en    = (state_q == S_ITER);
  assign bus.o_done        = (state_q == S_DONE);
  assign bus.o_count       = count_q;
  assign bus.o_div_by_zero = dz_q;
  assign bus.o_quotient    = res_q_q;
  assign bus.o_remainder   = res_r_q;
  assign bus.o_dbg_state   = state_q;

endmodule

// File: doc/mdr_div_sequencer.md
Name: mdr_div_sequencer

Overview:
Sequencer for the restoring radix-2 divider in the MDR system. It accepts a start/operand handshake and drives the shift-left quotient and partial-remainder registers for DW iterations. It then applies sign correction and returns quotient and remainder with a one-cycle done pulse. It sits between the MDR top-level operation decoder and the result mux.

Parameters:
DW, 16, operand/result width in bits
CW, $clog2(DW)+1, iteration counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
i_start  input  1  request; accepted only when o_ready=1
i_signed  input  1  1 = two's-complement operands; 0 = unsigned; sampled with i_start
i_dividend  input  DW  dividend, sampled with accepted i_start
i_divisor  input  DW  divisor, sampled with accepted i_start
o_ready  output  1  high only in IDLE
o_shift_en  output  1  quotient/remainder shift strobe, high during each ITER cycle
o_count  output  CW  iterations completed in the current operation
o_done  output  1  one-cycle pulse, results valid
o_div_by_zero  output  1  divisor was zero; held with results
o_quotient  output  DW  quotient, held until the next accepted start
o_remainder  output  DW  remainder, held until the next accepted start

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, o_ready=1; all other outputs and internal registers 0. rst overrides everything, including mid-operation; the partial result is discarded.
- FSM states: IDLE, LOAD, ITER, FIX, DONE.
- IDLE: i_start=1 at an edge latches operands, i_signed, neg_q = signed & (dividend[MSB]^divisor[MSB]), neg_r = signed & dividend[MSB] -> LOAD. o_quotient, o_remainder and o_div_by_zero clear on acceptance.
- LOAD (1 cycle): magnitude A = |dividend| and B = |divisor| when signed, else raw. rem=0, q=A, count=0.
  - divisor==0 -> DONE with q=all-ones, rem=original dividend, div_by_zero=1.
  - otherwise -> ITER.
- ITER (exactly DW cycles, o_shift_en=1):
  - {rem,q} <= {rem,q} << 1.
  - trial = shifted rem - B at DW+1 bits.
  - trial >= 0 -> rem=trial, q[0]=1; else q[0]=0.
  - count increments each cycle. -> FIX when count reaches DW-1 at the edge (DW shifts total).
- FIX (1 cycle): q = neg_q ? -q : q; rem = neg_r ? -rem : rem; two's-complement, DW-bit wrap -> DONE.
- DONE (1 cycle): o_done=1, outputs driven from q/rem -> IDLE.
- Latency: start accepted at edge 0 -> o_done high in cycle DW+3 (cycle 19 for DW=16). Divide-by-zero -> o_done in cycle 2.
- o_shift_en is never high outside ITER. It pulses exactly DW times per non-zero-divisor operation.
- i_start while o_ready=0 is ignored; operands are not resampled.
- Back-to-back: i_start high in the DONE cycle is ignored. i_start high in the following IDLE cycle is accepted, giving a minimum spacing of DW+4 cycles.
- Signed overflow: -2^(DW-1) / -1 gives q=2^(DW-1) (wraps to the most negative value), rem=0, no flag.
- Zero dividend: normal DW iterations, q=0, rem=0.
- Remainder sign always follows dividend sign; |rem| < |divisor|.

Test Plan:
- DW=16, unsigned 100/7, start at cycle 0 -> o_done in cycle 19, q=14 (0x000E), rem=2, dz=0; exactly 16 o_shift_en pulses.
- Signed -100/7 (0xFF9C/0x0007) -> q=0xFFF2 (-14), rem=0xFFFE (-2). Signed 100/-7 -> q=0xFFF2, rem=0x0002.
- 1234/0 (either mode) -> o_done in cycle 2, q=0xFFFF, rem=0x04D2, o_div_by_zero=1, zero o_shift_en pulses.
- Signed 0x8000/0xFFFF -> q=0x8000, rem=0x0000, dz=0. Unsigned 0xFFFF/0x0001 -> q=0xFFFF, rem=0.
- i_start pulsed with new operands (50/5) during ITER -> ignored; the original 100/7 result is returned. A second start in the IDLE cycle after DONE -> accepted, q=10, rem=0.
- rst=1 at the 8th ITER cycle -> next edge o_ready=1, all outputs 0, no o_done. A subsequent 9/4 -> q=2, rem=1.
